// File: rtl/mod_inv_param_if.sv
// ============================================================================
// Module  : mod_inv_param_if
// Brief   : Request/response bundle for the modular inverter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mod_inv_param_if #(
  parameter int WIDTH = 256
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] p_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [1:0]       err;
  logic             busy;

  modport master (
    output in_valid, a_in, p_in, out_ready,
    input  in_ready, out_valid, result, err, busy
  );

  modport slave (
    input  in_valid, a_in, p_in, out_ready,
    output in_ready, out_valid, result, err, busy
  );
endinterface

`default_nettype wire

// File: rtl/mod_inv_param.sv
// ============================================================================
// Module  : mod_inv_param
// Brief   : B = A^-1 mod P by binary extended Euclid, run-time modulus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mod_inv_param #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  mod_inv_param_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOOP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_zero  = '0;
  localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_three = WIDTH'(3);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_u, r_v, r_x1, r_x2, r_p;
  logic [WIDTH-1:0] w_u_nxt, w_v_nxt, w_x1_nxt, w_x2_nxt, w_p_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [1:0]       r_err, w_err_nxt;

  logic [WIDTH-1:0] w_x1_half, w_x2_half;
  logic [WIDTH:0]   w_uv_diff, w_x12_diff, w_x21_diff;
  logic [WIDTH-1:0] w_vu_diff, w_x12_mod, w_x21_mod;

  // P and an odd x are both odd, so (x+P)>>1 == (x>>1) + (P>>1) + 1 exactly.
  assign w_x1_half = r_x1[0] ? (r_x1 >> 1) + (r_p >> 1) + c_one : (r_x1 >> 1);
  assign w_x2_half = r_x2[0] ? (r_x2 >> 1) + (r_p >> 1) + c_one : (r_x2 >> 1);

  assign w_uv_diff  = {1'b0, r_u} - {1'b0, r_v};
  assign w_vu_diff  = r_v - r_u;
  assign w_x12_diff = {1'b0, r_x1} - {1'b0, r_x2};
  assign w_x21_diff = {1'b0, r_x2} - {1'b0, r_x1};
  assign w_x12_mod  = w_x12_diff[WIDTH] ? w_x12_diff[WIDTH-1:0] + r_p : w_x12_diff[WIDTH-1:0];
  assign w_x21_mod  = w_x21_diff[WIDTH] ? w_x21_diff[WIDTH-1:0] + r_p : w_x21_diff[WIDTH-1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_u_nxt      = r_u;
    w_v_nxt      = r_v;
    w_x1_nxt     = r_x1;
    w_x2_nxt     = r_x2;
    w_p_nxt      = r_p;
    w_result_nxt = r_result;
    w_err_nxt    = r_err;

    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_p_nxt = bus.p_in;
          if (!bus.p_in[0] || (bus.p_in < c_three)) begin
            w_err_nxt    = 2'd2;
            w_result_nxt = c_zero;
            w_state_nxt  = S_DONE;
          end else if (bus.a_in >= bus.p_in) begin
            w_err_nxt    = 2'd3;
            w_result_nxt = c_zero;
            w_state_nxt  = S_DONE;
          end else if (bus.a_in == c_zero) begin
            w_err_nxt    = 2'd1;
            w_result_nxt = c_zero;
            w_state_nxt  = S_DONE;
          end else begin
            w_u_nxt     = bus.a_in;
            w_v_nxt     = bus.p_in;
            w_x1_nxt    = c_one;
            w_x2_nxt    = c_zero;
            w_state_nxt = S_LOOP;
          end
        end
      end

      S_LOOP: begin
        if (r_u == c_one) begin
          w_result_nxt = r_x1;
          w_err_nxt    = 2'd0;
          w_state_nxt  = S_DONE;
        end else if (r_v == c_one) begin
          w_result_nxt = r_x2;
          w_err_nxt    = 2'd0;
          w_state_nxt  = S_DONE;
        end else if ((r_u == c_zero) || (r_v == c_zero)) begin
          w_result_nxt = c_zero;
          w_err_nxt    = 2'd1;
          w_state_nxt  = S_DONE;
        end else begin
          if (!r_u[0]) begin
            w_u_nxt  = r_u >> 1;
            w_x1_nxt = w_x1_half;
          end
          if (!r_v[0]) begin
            w_v_nxt  = r_v >> 1;
            w_x2_nxt = w_x2_half;
          end
          if (r_u[0] && r_v[0]) begin
            if (!w_uv_diff[WIDTH]) begin
              w_u_nxt  = w_uv_diff[WIDTH-1:0];
              w_x1_nxt = w_x12_mod;
            end else begin
              w_v_nxt  = w_vu_diff;
              w_x2_nxt = w_x21_mod;
            end
          end
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_result <= c_zero;
      r_err    <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Working registers carry no reset: they are always reloaded on accept.
  always_ff @(posedge clk) begin
    r_u  <= w_u_nxt;
    r_v  <= w_v_nxt;
    r_x1 <= w_x1_nxt;
    r_x2 <= w_x2_nxt;
    r_p  <= w_p_nxt;
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_LOOP) || (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: doc/mod_inv_param.md
# mod_inv_param

Parametrised modular inverter for the ECPA field-arithmetic layer. It computes B = A⁻¹ mod P with the binary extended-Euclidean (shift/subtract) method. The modulus is a run-time input rather than a compile-time constant, so one instance serves both the field prime and the group order. It adds a valid/ready handshake on both sides, argument checking with error codes, and an output that is always fully reduced.

## Interface
- WIDTH, 256, operand and modulus width in bits (≥ 4)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request (high only in IDLE)
- a_in  in  WIDTH  operand A
- p_in  in  WIDTH  modulus P
- out_valid  out  1  result/err valid; held until accepted
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  A⁻¹ mod P in [0, P); 0 when err ≠ 0
- err  out  2  0 = ok, 1 = not invertible (A = 0 or gcd(A,P) ≠ 1), 2 = bad modulus (P even or P < 3), 3 = A ≥ P
- busy  out  1  high in LOOP and DONE

## Operation
- States: IDLE, LOOP, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch P and check the arguments in priority order: err 2, then err 3, then err 1 for A = 0.
  - If any check fails: go to DONE with that err and result = 0.
  - Otherwise load u = A, v = P, x1 = 1, x2 = 0 and go to LOOP.
- LOOP (one iteration per cycle):
  - If u = 1: result ← x1, err ← 0, go to DONE.
  - Else if v = 1: result ← x2, err ← 0, go to DONE.
  - Else if u = 0 or v = 0: err ← 1, result ← 0, go to DONE.
  - Otherwise apply the two halving rules in the same cycle when both apply:
    - u even: u ← u>>1; x1 ← x1>>1 if x1 is even, else (x1+P)>>1 computed at WIDTH+1 bits.
    - v even: the same rule for v and x2.
  - If u and v are both odd, do one subtraction, compared at WIDTH+1 bits:
    - u ≥ v: u ← u−v, x1 ← x1−x2, plus P on borrow.
    - u < v: v ← v−u, x2 ← x2−x1, plus P on borrow.
- Invariant: x1 and x2 stay in [0, P) at all times, so no final reduction is needed.
- gcd ≠ 1 always ends with u = v, which leads to a zero and therefore err 1. No iteration cap is needed.
- DONE:
  - out_valid = 1; result and err are held stable.
  - On out_ready, go to IDLE next cycle.
  - in_valid is ignored while not in IDLE.
- Reset at any time, including mid-LOOP, aborts the operation.
  - Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, result 0, err 0.
  - Internal u, v, x1, x2 are don't-care after reset.

## Timing
- Accept cycle: in_valid & in_ready sampled high at an edge (cycle 0).
- Error path: out_valid is high from cycle 1.
- Normal path:
  - LOOP occupies cycles 1..N, and out_valid is high from cycle N+1.
  - N = 1 when A = 1.
  - N ≤ 2·WIDTH + 2 for any odd P < 2^WIDTH.
- Throughput: one operation in flight; a new request can be accepted from the cycle after the out_valid & out_ready handshake.
- out_valid is never deasserted without out_ready; result and err do not change while out_valid = 1.
- a_in and p_in are sampled only on the accept edge; they may change freely afterwards.

## Test plan
- WIDTH=8, P=7, A=3 → result=5, err=0. WIDTH=8, P=13, A=1 → result=1, out_valid at cycle 2.
- WIDTH=8, P=13: sweep A=1..12 → every result r satisfies A·r mod 13 = 1, and every N ≤ 18.
- WIDTH=8 error paths, each with out_valid at cycle 1 except P=9:
  - P=12, A=5 → err=2.
  - P=7, A=9 → err=3.
  - P=7, A=0 → err=1.
  - P=9, A=6 → err=1 (via LOOP), result=0.
- WIDTH=256, P = secp256k1 prime, A=2 → result = (P+1)/2; A = P−1 → result = P−1.
- Backpressure: P=7, A=3 with out_ready held low 5 cycles after out_valid → result=5 stable, in_ready=0 throughout, accept on the 6th cycle. A back-to-back second request (A=2 → 4) is accepted the cycle after the handshake.
- Reset: assert rst during LOOP (P=13, A=7) → out_valid=0, busy=0 immediately. Release, then request A=7 → result=2.
